instr_encoder: RTL



---
 rtl/instr_encoder_if.sv | 26 ++
 rtl/instr_encoder.sv | 122 ++++++++++++
 2 files changed

// File: rtl/instr_encoder_if.sv
// Handshake bundle between fetch, the instruction encoder and the decode stage.
// The master side is the surrounding pipeline (fetch + decode); the slave side
// is the encoder itself.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_code;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_code, out_instr, out_pc, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_code, out_instr, out_pc, out_illegal
    );
endinterface

// File: rtl/instr_encoder.sv
// Instruction classifier for the MIPS front end: maps raw words to the 4-bit
// code the control decoder uses and buffers {code, instr, pc} in a 2-entry
// skid FIFO so that in_ready and out_valid both come straight from flops.
module instr_encoder (
    input  logic            clk,
    input  logic            rst_n,
    instr_encoder_if.slave  bus
);

    localparam logic [3:0] CODE_ADDU    = 4'h0;
    localparam logic [3:0] CODE_SUBU    = 4'h1;
    localparam logic [3:0] CODE_ORI     = 4'h2;
    localparam logic [3:0] CODE_LW      = 4'h3;
    localparam logic [3:0] CODE_SW      = 4'h4;
    localparam logic [3:0] CODE_BEQ     = 4'h5;
    localparam logic [3:0] CODE_LUI     = 4'h6;
    localparam logic [3:0] CODE_JAL     = 4'h7;
    localparam logic [3:0] CODE_JR      = 4'h8;
    localparam logic [3:0] CODE_SLL     = 4'h9;
    localparam logic [3:0] CODE_ILLEGAL = 4'hF;

    logic [1:0]  count_q, count_d;
    logic        rdPtr_q, rdPtr_d;
    logic        wrPtr_q, wrPtr_d;
    logic        inReady_q;
    logic        outValid_q;
    logic [3:0]  code_q  [2];
    logic [31:0] instr_q [2];
    logic [31:0] pc_q    [2];
    logic [3:0]  inCode;
    logic        push;
    logic        pop;

    // Classify the incoming word from opcode, and from funct for R-type words.
    always_comb begin
        inCode = CODE_ILLEGAL;
        case (bus.in_instr[31:26])
            6'b000000: begin
                case (bus.in_instr[5:0])
                    6'b100001: inCode = CODE_ADDU;
                    6'b100011: inCode = CODE_SUBU;
                    6'b000000: inCode = CODE_SLL;
                    6'b001000: inCode = CODE_JR;
                    default:   inCode = CODE_ILLEGAL;
                endcase
            end
            6'b001101: inCode = CODE_ORI;
            6'b100011: inCode = CODE_LW;
            6'b101011: inCode = CODE_SW;
            6'b000100: inCode = CODE_BEQ;
            6'b001111: inCode = CODE_LUI;
            6'b000011: inCode = CODE_JAL;
            default:   inCode = CODE_ILLEGAL;
        endcase
    end

    // Next pointers and occupancy; a flush wins over any push or pop.
    always_comb begin
        push    = bus.in_valid & inReady_q;
        pop     = outValid_q & bus.out_ready;
        count_d = count_q;
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        if (bus.flush) begin
            count_d = 2'd0;
            rdPtr_d = 1'b0;
            wrPtr_d = 1'b0;
        end else begin
            if (push) begin
                wrPtr_d = ~wrPtr_q;
            end
            if (pop) begin
                rdPtr_d = ~rdPtr_q;
            end
            if (push && !pop) begin
                count_d = count_q + 2'd1;
            end else if (pop && !push) begin
                count_d = count_q - 2'd1;
            end
        end
    end

    // Occupancy, pointers and the registered handshake flags derived from next count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= 2'd0;
            rdPtr_q    <= 1'b0;
            wrPtr_q    <= 1'b0;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            inReady_q  <= (count_d < 2'd2);
            outValid_q <= (count_d != 2'd0);
        end
    end

    // Entry storage: capture code, word and PC into the write slot on a push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                code_q[i]  <= 4'h0;
                instr_q[i] <= 32'h0;
                pc_q[i]    <= 32'h0;
            end
        end else if (!bus.flush && push) begin
            code_q[wrPtr_q]  <= inCode;
            instr_q[wrPtr_q] <= bus.in_instr;
            pc_q[wrPtr_q]    <= bus.in_pc;
        end
    end

    assign bus.in_ready    = inReady_q;
    assign bus.out_valid   = outValid_q;
    assign bus.out_code    = code_q[rdPtr_q];
    assign bus.out_instr   = instr_q[rdPtr_q];
    assign bus.out_pc      = pc_q[rdPtr_q];
    assign bus.out_illegal = (code_q[rdPtr_q] == CODE_ILLEGAL);

endmodule
